// File: rtl/jorge_game.sv
// "Catch the light" reaction game: a lit LED sweeps the LED bar and the player
// hits while it sits on the switch-selected target. The score is shown on a 7-segment display.
module jorge_game #(
  parameter int TICK_PERIOD = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  // state | meaning
  // IDLE  | after reset, waiting for start, LED bar dark
  // RUN   | light sweeping, hits judged against target
  // WIN   | nine catches, LED bar blinks at tick rate
  // LOSE  | lives exhausted, LED bar dark, game-over flag set

  localparam int CW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_PERIOD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WIN = 2'd2, LOSE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [3:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [2:0]    pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic          win_on_q, win_on_d;

  logic       hit_s1, hit_s2, hit_p;
  logic       start_s1, start_s2, start_p;
  logic [2:0] tgt_s1, tgt_s2;

  logic hit_ev, start_ev, tick;
  logic unused_in;

  assign unused_in = ^{uio_in, ui_in[7:5]};

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_s1   <= 1'b0;
      hit_s2   <= 1'b0;
      hit_p    <= 1'b0;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_p  <= 1'b0;
      tgt_s1   <= 3'd0;
      tgt_s2   <= 3'd0;
    end else if (ena) begin
      hit_s1   <= ui_in[0];
      hit_s2   <= hit_s1;
      hit_p    <= hit_s2;
      start_s1 <= ui_in[1];
      start_s2 <= start_s1;
      start_p  <= start_s2;
      tgt_s1   <= ui_in[4:2];
      tgt_s2   <= tgt_s1;
    end
  end

  assign hit_ev   = hit_s2 & ~hit_p;
  assign start_ev = start_s2 & ~start_p;
  assign tick     = (state_q == RUN) && (cnt_q == TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      score_q   <= 4'd0;
      lives_q   <= 2'd3;
      pos_q     <= 3'd0;
      cnt_q     <= '0;
      win_cnt_q <= '0;
      win_on_q  <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      win_cnt_q <= win_cnt_d;
      win_on_q  <= win_on_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    win_cnt_d = win_cnt_q;
    win_on_d  = win_on_q;
    case (state_q)
      RUN: begin
        if (tick) begin
          cnt_d = '0;
          pos_d = pos_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // hit is judged on the pre-advance position even when a tick coincides
        if (hit_ev) begin
          if (pos_q == tgt_s2) begin
            score_d = score_q + 4'd1;
            if (score_q == 4'd8) begin
              state_d   = WIN;
              win_cnt_d = '0;
              win_on_d  = 1'b1;
            end
          end else begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) state_d = LOSE;
          end
        end
      end
      WIN: begin
        if (win_cnt_q == TC) begin
          win_cnt_d = '0;
          win_on_d  = ~win_on_q;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (start_ev && (state_q != RUN)) begin
      state_d = RUN;
      score_d = 4'd0;
      lives_d = 2'd3;
      pos_d   = 3'd0;
      cnt_d   = '0;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    uio_out = 8'h00;
    case (state_q)
      RUN:     uio_out = 8'h01 << pos_q;
      WIN:     uio_out = {8{win_on_q}};
      default: uio_out = 8'h00;
    endcase
  end

  assign uo_out = {(state_q == LOSE), seg7(score_q)};
  assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_jorge_game.sv
// Scoreboard bench for jorge_game: expectations are queued with the cycle they
// fall due, and a negedge monitor compares them against the outputs.
module tb_jorge_game;
  localparam int TP = 4;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  jorge_game #(.TICK_PERIOD(TP)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         at;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   t0 = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %02h expected %02h", tag, cyc, got, want);
    end
  endtask

  task automatic push(input string tag, input int at, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.at  = at;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [7:0] got;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        e = sb[i];
        sb.delete(i);
        got = (e.sel == 0) ? uo_out : (e.sel == 1) ? uio_out : uio_oe;
        check_val(e.tag, got, e.val);
      end
    end
  end

  function automatic int pos_at(input int c);
    return ((c - t0) / TP) % 8;
  endfunction

  // start press lasting one cycle; RUN is entered on the 3rd edge after the drive
  task automatic press_start(input logic with_hit);
    ui_in[1] = 1'b1;
    if (with_hit) ui_in[0] = 1'b1;
    @(negedge clk);
    ui_in[1] = 1'b0;
    ui_in[0] = 1'b0;
    t0 = cyc + 2;
  endtask

  // drive a hit so the event lands while the light is on 'want'
  task automatic hit(input string tag, input int want, input int hold,
                     input logic [7:0] exp_uo, output int eff);
    int n = 0;
    while (!(cyc >= t0 && ((cyc - t0) % TP) == 1 && pos_at(cyc) == want) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check_val({tag, "_wait"}, 8'(n), 8'd0);
    ui_in[0] = 1'b1;
    eff = cyc + 3;
    push(tag, eff, 0, exp_uo);
    push({tag, "_hold"}, eff + hold + 3, 0, exp_uo);
    repeat (hold) @(negedge clk);
    ui_in[0] = 1'b0;
  endtask

  initial begin
    int eff, c, t0n;
    logic [7:0] frozen;
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    push("rst_uo", 2, 0, 8'h3F);
    push("rst_uio", 2, 1, 8'h00);
    push("rst_oe", 2, 2, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push("idle_uo", cyc + 50, 0, 8'h3F);
    push("idle_uio", cyc + 50, 1, 8'h00);
    push("idle_end_uo", cyc + 100, 0, 8'h3F);
    push("idle_end_uio", cyc + 100, 1, 8'h00);
    push("idle_end_oe", cyc + 100, 2, 8'hFF);
    repeat (20) @(negedge clk);
    ui_in[0] = 1'b1;
    @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (79) @(negedge clk);

    ui_in[4:2] = 3'd3;
    repeat (3) @(negedge clk);
    press_start(1'b0);
    push("start_uo", t0, 0, 8'h3F);
    for (int k = 0; k < 36; k++) push("sweep", t0 + k, 1, 8'h01 << ((k / TP) % 8));
    while (cyc < t0 + 36) @(negedge clk);

    hit("catch", 3, 8, 8'h06, eff);
    hit("miss1", 6, 1, 8'h06, eff);
    hit("miss2", 1, 1, 8'h06, eff);
    hit("miss3", 4, 1, 8'h86, eff);
    push("lose_uio", eff, 1, 8'h00);
    push("lose_uio2", eff + 1, 1, 8'h00);
    repeat (4) @(negedge clk);
    ui_in[0] = 1'b1;
    push("lose_hit_uo", cyc + 3, 0, 8'h86);
    push("lose_hit_uo2", cyc + 6, 0, 8'h86);
    push("lose_hit_uio", cyc + 6, 1, 8'h00);
    @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    press_start(1'b0);
    push("restart_uo", t0, 0, 8'h3F);
    push("restart_uio", t0, 1, 8'h01);

    for (int s = 1; s <= 9; s++) hit($sformatf("win%0d", s), 3, 1, seg_tab[s], eff);
    for (int k = 0; k < 16; k++) push("win_blink", eff + k, 1, (((k / TP) % 2) == 0) ? 8'hFF : 8'h00);
    push("win_uo", eff + 15, 0, 8'h6F);
    while (cyc < eff + 16) @(negedge clk);
    press_start(1'b1);
    push("win_restart_uo", t0, 0, 8'h3F);
    push("win_restart_uio", t0, 1, 8'h01);
    push("win_restart_uio2", t0 + 4, 1, 8'h02);

    while (cyc < t0 + 6) @(negedge clk);
    c = cyc;
    frozen = 8'h01 << pos_at(c);
    t0n = t0 + 20;
    for (int k = 1; k <= 20; k++) push("ena_frozen", c + k, 1, frozen);
    for (int k = 21; k <= 30; k++) push("ena_resume", c + k, 1, 8'h01 << (((c + k - t0n) / TP) % 8));
    push("ena_hit_ignored", c + 25, 0, 8'h3F);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ui_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    ena = 1'b1;
    t0 = t0n;
    hit("ena_catch", 3, 1, 8'h06, eff);
    repeat (6) @(negedge clk);

    push("midrst_uo", cyc + 1, 0, 8'h3F);
    push("midrst_uio", cyc + 1, 1, 8'h00);
    push("midrst_uio_after", cyc + 5, 1, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    check_val("sb_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jorge_game.md
Name: jorge_game

Overview:
- "Catch the light" reaction game for a Tiny Tapeout tile.
- A single lit LED sweeps across 8 LEDs on uio_out; the player presses a hit button while the light sits on a switch-selected target position.
- Score (0-9) is shown on a 7-segment display on uo_out. Three misses end the game; nine catches win it.
- Top-level user block of the tile, using the standard TT pinout except that reset is active-high.

Parameters:
TICK_PERIOD, 2500000, clock cycles per LED step (10 Hz at 25 MHz); must be >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
ena  input  1  tile enable; when low all state (including synchronizers and tick counter) holds
ui_in  input  8  [0]=hit button, [1]=start button, [4:2]=target LED index 0-7, [7:5] unused
uo_out  output  8  [6:0]=7-seg segments a..g (bit0=a, active-high), [7]=game-over flag
uio_in  input  8  unused, ignored
uio_out  output  8  LED bar
uio_oe  output  8  constant 8'hFF

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst overrides ena.
- Reset values: state=IDLE, score=0, lives=3, pos=0, tick counter=0, synchronizers=0, uio_out=8'h00, uo_out=8'h3F, uio_oe=8'hFF.
- Input conditioning:
  - ui_in[0] and ui_in[1] each pass through 2 flops (s1, s2) plus a previous-value flop p.
  - Press event = s2 & ~p.
  - A button rising at the input produces its state effect at the 3rd rising clk edge after it is sampled high.
  - Holding a button produces exactly one event.
- Tick counter:
  - Counts 0..TICK_PERIOD-1 only in RUN.
  - tick = 1 when count == TICK_PERIOD-1; count then wraps to 0.
  - Cleared on entry to RUN.
- States: IDLE, RUN, WIN, LOSE.
  - IDLE/WIN/LOSE + start event -> RUN; score=0, lives=3, pos=0, counter=0.
  - RUN: on tick, pos = pos+1 mod 8 (7 wraps to 0).
  - RUN + hit event with pos == target: score+1. If the new score is 9 -> WIN.
  - RUN + hit event with pos != target: lives-1. If the new lives is 0 -> LOSE. Score unchanged.
  - Start event in RUN is ignored. Hit events outside RUN are ignored.
  - Hit and tick in the same cycle: the hit is judged against the pre-advance pos; pos still advances.
  - Hit and start in the same cycle outside RUN: start wins.
  - Target is sampled (after the same 2-flop sync) at the moment of the hit event.
- Outputs:
  - uio_out: IDLE=8'h00; RUN=one-hot (1<<pos).
  - WIN: 8'hFF. A WIN toggle flop runs its own TICK_PERIOD counter and alternates uio_out between 8'hFF and 8'h00 on each tick.
  - LOSE: 8'h00.
  - uo_out[6:0] = 7-seg of score in every state: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
  - uo_out[7] = 1 only in LOSE.
  - All outputs are registered or decoded from registers; no combinational path from ui_in.
- Widths: score 4 bits (never exceeds 9), lives 2 bits, pos 3 bits, counter ceil(log2(TICK_PERIOD)) bits.

Test Plan:
All scenarios use TICK_PERIOD=4.
1. Reset: rst=1 for 2 cycles -> uo_out=8'h3F, uio_out=8'h00, uio_oe=8'hFF; 100 idle cycles with no button -> unchanged.
2. Start and sweep: pulse ui_in[1] -> uio_out=8'h01; it then shifts left every 4 cycles: 02, 04, ... 80, then wraps to 01.
3. Catch: target=3 (ui_in[4:2]=3'b011); press hit while uio_out=8'h08, timed so the event lands inside the window -> uo_out goes 8'h3F -> 8'h06. Holding the button gives no second increment.
4. Miss to LOSE: three hits with pos != target -> uo_out[7]=1, uio_out=8'h00, score display retained. A further hit changes nothing; start -> RUN with 8'h3F and uio_out=8'h01.
5. Win: nine correct hits -> uo_out[6:0]=7'h6F; uio_out toggles FF/00 every 4 cycles; start restarts at score 0.
6. ena=0 mid-RUN for 20 cycles -> uio_out frozen and button presses ignored. rst asserted mid-RUN -> IDLE values at the next edge.
